// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and line-level constants for the UART transmitter
package uart_pkg;
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/uart_tx_frame_if.sv
// rtl/uart_tx_frame_if.sv - payload/parity inputs and serial/busy outputs of the UART frame transmitter
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  BUSY;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    input  TX_OUT, BUSY
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    output TX_OUT, BUSY
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - payload shift register and bit counter; done flags the last data bit on the line
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  shift,
  input  logic                  count,
  output logic                  bit_out,
  output logic                  done
);
  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0]      cnt_q;

  // Shift and count are separate so the start-bit cycle can pre-shift bit 0 without advancing the count.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shreg_q <= load_data;
      cnt_q   <= '0;
    end else begin
      if (shift) shreg_q <= shreg_q >> 1;
      if (count) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bit_out = shreg_q[0];
  assign done    = (cnt_q == CNT_W'(DATA_WIDTH - 1));
endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART frame transmitter, one bit per clock
// Parity bit and PAR_EN/PAR_TYP latches are built only when UART_TX_FRAME_PARITY_EN is defined.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input logic            CLK,
  input logic            RST,
  uart_tx_frame_if.slave tx_if
);
  state_t state_q, state_d;
  logic   tx_q, tx_d;
  logic   busy_q, busy_d;
  logic   ser_load, ser_shift, ser_count;
  logic   ser_bit, ser_done;

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .CLK       (CLK),
    .RST       (RST),
    .load      (ser_load),
    .load_data (tx_if.P_DATA),
    .shift     (ser_shift),
    .count     (ser_count),
    .bit_out   (ser_bit),
    .done      (ser_done)
  );

`ifdef UART_TX_FRAME_PARITY_EN
  logic par_en_q, par_q;

  // Parity is folded at acceptance since the shift register no longer holds the whole byte later.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
    end else if (ser_load) begin
      par_en_q <= tx_if.PAR_EN;
      par_q    <= (^tx_if.P_DATA) ^ (tx_if.PAR_TYP == PAR_ODD);
    end
  end
`else
  logic unused_par;
  assign unused_par = tx_if.PAR_EN ^ tx_if.PAR_TYP;
`endif

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    ser_count = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d   = IDLE_LEVEL;
        busy_d = 1'b0;
        if (tx_if.DATA_VALID) begin
          state_d  = ST_START;
          tx_d     = START_BIT;
          busy_d   = 1'b1;
          ser_load = 1'b1;
        end
      end
      ST_START: begin
        state_d   = ST_DATA;
        tx_d      = ser_bit;
        ser_shift = 1'b1;
      end
      ST_DATA: begin
        if (ser_done) begin
`ifdef UART_TX_FRAME_PARITY_EN
          if (par_en_q) begin
            state_d = ST_PARITY;
            tx_d    = par_q;
          end else begin
            state_d = ST_STOP;
            tx_d    = STOP_BIT;
          end
`else
          state_d = ST_STOP;
          tx_d    = STOP_BIT;
`endif
        end else begin
          tx_d      = ser_bit;
          ser_shift = 1'b1;
          ser_count = 1'b1;
        end
      end
      ST_PARITY: begin
        state_d = ST_STOP;
        tx_d    = STOP_BIT;
      end
      ST_STOP: begin
        state_d = ST_IDLE;
        tx_d    = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      tx_q    <= IDLE_LEVEL;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign tx_if.TX_OUT = tx_q;
  assign tx_if.BUSY   = busy_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - directed vector bench for uart_tx_frame
module tb_uart_tx_frame;
  localparam int DW = 8;
`ifdef UART_TX_FRAME_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  uart_tx_frame_if #(.DATA_WIDTH(DW)) u_if ();

  uart_tx_frame #(.DATA_WIDTH(DW)) dut (
    .CLK   (clk),
    .RST   (rst),
    .tx_if (u_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic       par;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses DATA_VALID for one edge, then records TX_OUT for every cycle BUSY is high.
  task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                           output logic [15:0] cap, output int blen);
    u_if.P_DATA     = d;
    u_if.PAR_EN     = pe;
    u_if.PAR_TYP    = pt;
    u_if.DATA_VALID = 1'b1;
    tick();
    u_if.DATA_VALID = 1'b0;
    cap  = '0;
    blen = 0;
    while (u_if.BUSY === 1'b1 && blen < 16) begin
      cap[blen] = u_if.TX_OUT;
      blen++;
      tick();
    end
  endtask

  function automatic logic [15:0] exp_frame(input logic [7:0] d, input logic has_par, input logic par);
    logic [15:0] e;
    e      = '0;
    e[8:0] = {d, 1'b0};
    if (has_par) begin
      e[9]  = par;
      e[10] = 1'b1;
    end else begin
      e[9] = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [7:0] pat(input int j);
    return 8'((j * 37) ^ 32'hC3);
  endfunction

  initial begin
    logic [15:0] cap;
    int          blen;
    int          bad;
    logic        has_par;
    logic [32:0] tx_tr, busy_tr, exp_tx, exp_busy;
    logic [7:0]  d;
    int          rises;

    vecs[0] = '{data: 8'hA5, pe: 1'b0, pt: 1'b0, par: 1'b0};
    vecs[1] = '{data: 8'h07, pe: 1'b1, pt: 1'b0, par: 1'b1};
    vecs[2] = '{data: 8'h07, pe: 1'b1, pt: 1'b1, par: 1'b0};
    vecs[3] = '{data: 8'h01, pe: 1'b1, pt: 1'b0, par: 1'b1};
    vecs[4] = '{data: 8'hA5, pe: 1'b1, pt: 1'b1, par: 1'b1};
    vecs[5] = '{data: 8'hFF, pe: 1'b1, pt: 1'b0, par: 1'b0};
    vecs[6] = '{data: 8'h00, pe: 1'b1, pt: 1'b1, par: 1'b1};
    vecs[7] = '{data: 8'h3C, pe: 1'b0, pt: 1'b1, par: 1'b0};

    u_if.P_DATA     = '0;
    u_if.DATA_VALID = 1'b0;
    u_if.PAR_EN     = 1'b0;
    u_if.PAR_TYP    = 1'b0;
    rst             = 1'b0;

    repeat (3) tick();
    check("reset_state", {62'd0, u_if.BUSY, u_if.TX_OUT}, 64'b01);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (u_if.TX_OUT !== 1'b1 || u_if.BUSY !== 1'b0) bad++;
    end
    check("idle_hold_bad_cycles", 64'(bad), 64'd0);

    for (int i = 0; i < 8; i++) begin
      has_par = PAR_BUILD && vecs[i].pe;
      run_frame(vecs[i].data, vecs[i].pe, vecs[i].pt, cap, blen);
      check($sformatf("vec%0d_bits", i), 64'(cap), 64'(exp_frame(vecs[i].data, has_par, vecs[i].par)));
      check($sformatf("vec%0d_busy_len", i), 64'(blen), has_par ? 64'd11 : 64'd10);
      check($sformatf("vec%0d_idle_after", i), {62'd0, u_if.BUSY, u_if.TX_OUT}, 64'b01);
    end

    // DATA_VALID held high while P_DATA changes every cycle: only edges 0, 11, 22 accept.
    u_if.PAR_EN  = 1'b0;
    u_if.PAR_TYP = 1'b0;
    for (int j = 0; j < 33; j++) begin
      u_if.P_DATA     = pat(j);
      u_if.DATA_VALID = 1'b1;
      tick();
      tx_tr[j]   = u_if.TX_OUT;
      busy_tr[j] = u_if.BUSY;
    end
    u_if.DATA_VALID = 1'b0;
    for (int m = 0; m < 3; m++) begin
      d = pat(11 * m);
      exp_tx[11*m]   = 1'b0;
      exp_busy[11*m] = 1'b1;
      for (int i = 0; i < 8; i++) begin
        exp_tx[11*m+1+i]   = d[i];
        exp_busy[11*m+1+i] = 1'b1;
      end
      exp_tx[11*m+9]    = 1'b1;
      exp_busy[11*m+9]  = 1'b1;
      exp_tx[11*m+10]   = 1'b1;
      exp_busy[11*m+10] = 1'b0;
    end
    rises = 0;
    for (int j = 0; j < 33; j++)
      if (busy_tr[j] && (j == 0 || !busy_tr[j-1])) rises++;
    check("held_valid_tx_trace", 64'(tx_tr), 64'(exp_tx));
    check("held_valid_busy_trace", 64'(busy_tr), 64'(exp_busy));
    check("held_valid_busy_rises", 64'(rises), 64'd3);
    tick();
    check("held_valid_quiet", {62'd0, u_if.BUSY, u_if.TX_OUT}, 64'b01);

    // Reset while data bit 3 of 0xFF is on the line, then a clean 0x3C frame.
    u_if.P_DATA     = 8'hFF;
    u_if.DATA_VALID = 1'b1;
    tick();
    u_if.DATA_VALID = 1'b0;
    u_if.P_DATA     = 8'h00;
    repeat (4) tick();
    check("midrst_before", {62'd0, u_if.BUSY, u_if.TX_OUT}, 64'b11);
    rst = 1'b0;
    tick();
    check("midrst_after", {62'd0, u_if.BUSY, u_if.TX_OUT}, 64'b01);
    tick();
    rst = 1'b1;
    run_frame(8'h3C, 1'b0, 1'b0, cap, blen);
    check("post_rst_bits", 64'(cap), 64'(exp_frame(8'h3C, 1'b0, 1'b0)));
    check("post_rst_busy_len", 64'(blen), 64'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
